uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO and start/done sequencer feeding a UART transmitter.
// Bytes are queued on single-cycle pushes and issued one at a time, each start waiting for the previous done.
module uart_tx_fifo #(
   parameter int unsigned NB_DATA    = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [NB_DATA-1:0]    i_data,
   input  logic                  i_clr_ovf,
   input  logic                  i_txdone,
   output logic                  o_tx_start,
   output logic [NB_DATA-1:0]    o_tx_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_busy
);

   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned NB_CNT = DEPTH_LOG2 + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d;
   logic [NB_CNT-1:0]      count_q, count_d;
   logic                   tx_start_q, tx_start_d;
   logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
   logic                   ovf_q, ovf_d;
   logic [NB_DATA-1:0]     mem_q [DEPTH];

   logic                   full_c;
   logic                   pop_c;
   logic                   push_ok_c;
   logic                   drop_c;

   // Pop decision looks only at the registered count, so a same-cycle push is never popped.
   assign full_c    = (count_q == NB_CNT'(DEPTH));
   assign pop_c     = (state_q == ST_IDLE) && (count_q != '0);
   assign push_ok_c = i_push && (!full_c || pop_c);
   assign drop_c    = i_push && full_c && !pop_c;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      ovf_d      = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (pop_c) begin
               rptr_d     = rptr_q + DEPTH_LOG2'(1);
               tx_data_d  = mem_q[rptr_q];
               tx_start_d = 1'b1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_txdone) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (push_ok_c) begin
         wptr_d = wptr_q + DEPTH_LOG2'(1);
      end

      case ({push_ok_c, pop_c})
         2'b10:   count_d = count_q + NB_CNT'(1);
         2'b01:   count_d = count_q - NB_CNT'(1);
         default: count_d = count_q;
      endcase

      // A dropped push outranks a same-cycle clear.
      if (drop_c) begin
         ovf_d = 1'b1;
      end else if (i_clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage array carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_q[wptr_q] <= i_data;
      end
   end

   assign o_tx_start = tx_start_q;
   assign o_tx_data  = tx_data_q;
   assign o_full     = full_c;
   assign o_empty    = (count_q == '0);
   assign o_count    = count_q;
   assign o_overflow = ovf_q;
   assign o_busy     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and a random run
// compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       i_push;
   logic [7:0] i_data;
   logic       i_clr_ovf;
   logic       i_txdone;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_full;
   logic       o_empty;
   logic [4:0] o_count;
   logic       o_overflow;
   logic       o_busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a byte queue plus a "transmitter owned" flag
   logic [7:0] exp_q[$];
   logic       m_busy;
   logic       m_start;
   logic [7:0] m_data;
   logic       m_ovf;
   logic       prev_start;
   logic [7:0] starts_q[$];

   uart_tx_fifo #(.NB_DATA(8), .DEPTH_LOG2(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_push     (i_push),
      .i_data     (i_data),
      .i_clr_ovf  (i_clr_ovf),
      .i_txdone   (i_txdone),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy     = 1'b0;
      m_start    = 1'b0;
      m_data     = 8'h00;
      m_ovf      = 1'b0;
      prev_start = 1'b0;
   endtask

   // One clock edge of the specified behaviour, evaluated on the queue.
   task automatic model_step(input logic p, input logic [7:0] d, input logic c, input logic t);
      logic pop;
      logic full;
      pop     = !m_busy && (exp_q.size() != 0);
      full    = (exp_q.size() == 16);
      m_start = 1'b0;
      if (pop) begin
         m_data  = exp_q.pop_front();
         m_start = 1'b1;
         m_busy  = 1'b1;
      end else if (m_busy && t) begin
         m_busy = 1'b0;
      end
      if (p && (!full || pop)) exp_q.push_back(d);
      if (p && full && !pop) m_ovf = 1'b1;
      else if (c)            m_ovf = 1'b0;
   endtask

   task automatic check_model();
      chk("tx_start", 32'(o_tx_start), 32'(m_start));
      chk("tx_data",  32'(o_tx_data),  32'(m_data));
      chk("count",    32'(o_count),    32'(exp_q.size()));
      chk("full",     32'(o_full),     32'(exp_q.size() == 16));
      chk("empty",    32'(o_empty),    32'(exp_q.size() == 0));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("busy",     32'(o_busy),     32'(m_busy));
      chk("start_width", 32'(o_tx_start & prev_start), 32'd0);
   endtask

   task automatic cycle(input logic p, input logic [7:0] d, input logic c, input logic t);
      i_push    = p;
      i_data    = d;
      i_clr_ovf = c;
      i_txdone  = t;
      @(posedge clk);
      model_step(p, d, c, t);
      #1;
      check_model();
      if (o_tx_start) starts_q.push_back(o_tx_data);
      prev_start = o_tx_start;
      i_push    = 1'b0;
      i_clr_ovf = 1'b0;
      i_txdone  = 1'b0;
   endtask

   task automatic reset_values(input string tag);
      chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
      chk({tag, "_data"},  32'(o_tx_data),  32'd0);
      chk({tag, "_count"}, 32'(o_count),    32'd0);
      chk({tag, "_full"},  32'(o_full),     32'd0);
      chk({tag, "_empty"}, 32'(o_empty),    32'd1);
      chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
      chk({tag, "_busy"},  32'(o_busy),     32'd0);
   endtask

   // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
   task automatic apply_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      reset_values(tag);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 4000 && (exp_q.size() != 0 || m_busy); n++)
         cycle(1'b0, 8'h00, 1'b0, m_busy && ($urandom_range(0, 3) == 0));
      chk("drain_idle", {30'd0, o_empty, o_busy}, 32'b10);
   endtask

   typedef struct {
      logic       push;
      logic [7:0] data;
      logic       clr;
      logic       done;
      logic       e_start;
      logic [7:0] e_data;
      logic [4:0] e_count;
      logic       e_ovf;
      logic       e_busy;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [7:0] exp_b;
      int         wait_cnt;
      rst       = 1'b1;
      i_push    = 1'b0;
      i_data    = 8'h00;
      i_clr_ovf = 1'b0;
      i_txdone  = 1'b0;
      model_reset();
      #3;
      reset_values("por");
      @(negedge clk);
      rst = 1'b0;

      // Single byte, stray done, push+pop overlap
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4D, 5'd0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4D, 5'd0, 1'b0, 1'b0};
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].push, vecs[i].data, vecs[i].clr, vecs[i].done);
         chk($sformatf("vec%0d_start", i), 32'(o_tx_start), 32'(vecs[i].e_start));
         chk($sformatf("vec%0d_data", i),  32'(o_tx_data),  32'(vecs[i].e_data));
         chk($sformatf("vec%0d_count", i), 32'(o_count),    32'(vecs[i].e_count));
         chk($sformatf("vec%0d_ovf", i),   32'(o_overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_busy", i),  32'(o_busy),     32'(vecs[i].e_busy));
      end

      // Burst of three, each answered 20 cycles after its start
      apply_reset("rst_burst");
      starts_q.delete();
      for (int b = 1; b <= 3; b++) cycle(1'b1, 8'(b), 1'b0, 1'b0);
      wait_cnt = 0;
      for (int n = 0; n < 500 && (starts_q.size() < 3 || m_busy); n++) begin
         cycle(1'b0, 8'h00, 1'b0, m_busy && (wait_cnt == 19));
         wait_cnt = o_tx_start ? 0 : wait_cnt + 1;
      end
      chk("burst_nstarts", 32'(starts_q.size()), 32'd3);
      for (int b = 0; b < 3 && b < starts_q.size(); b++)
         chk($sformatf("burst_byte%0d", b), 32'(starts_q[b]), 32'(b + 1));

      // Fill, overflow, clear, then push on the pop cycle while full
      apply_reset("rst_fill");
      starts_q.delete();
      for (int b = 0; b < 17; b++) cycle(1'b1, 8'(8'h10 + b), 1'b0, 1'b0);
      chk("fill_count", 32'(o_count), 32'd16);
      chk("fill_full", 32'(o_full), 32'd1);
      chk("fill_ovf", 32'(o_overflow), 32'd0);
      cycle(1'b1, 8'h30, 1'b0, 1'b0);
      cycle(1'b1, 8'h31, 1'b0, 1'b0);
      chk("ovf_set", 32'(o_overflow), 32'd1);
      chk("ovf_full", 32'(o_full), 32'd1);
      cycle(1'b1, 8'h32, 1'b1, 1'b0);
      chk("ovf_set_wins", 32'(o_overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ovf_clr", 32'(o_overflow), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h99, 1'b0, 1'b0);
      chk("fullpop_count", 32'(o_count), 32'd16);
      chk("fullpop_ovf", 32'(o_overflow), 32'd0);
      chk("fullpop_start", 32'(o_tx_start), 32'd1);
      drain();
      chk("fill_nstarts", 32'(starts_q.size()), 32'd18);
      for (int b = 0; b < 17 && b < starts_q.size(); b++)
         chk($sformatf("fill_byte%0d", b), 32'(starts_q[b]), 32'(8'h10 + b));
      if (starts_q.size() != 0)
         chk("fullpop_last", 32'(starts_q[starts_q.size() - 1]), 32'h99);

      // Forty bytes in batches of ten, pointers wrap twice
      apply_reset("rst_wrap");
      starts_q.delete();
      for (int batch = 0; batch < 4; batch++) begin
         for (int b = 0; b < 10; b++) cycle(1'b1, 8'(batch * 10 + b), 1'b0, 1'b0);
         drain();
      end
      chk("wrap_nstarts", 32'(starts_q.size()), 32'd40);
      for (int b = 0; b < 40 && b < starts_q.size(); b++) begin
         exp_b = 8'(b);
         if (starts_q[b] !== exp_b) chk($sformatf("wrap_byte%0d", b), 32'(starts_q[b]), 32'(exp_b));
      end
      chk("wrap_ovf", 32'(o_overflow), 32'd0);

      // Reset while waiting with five bytes queued
      for (int b = 0; b < 6; b++) cycle(1'b1, 8'(8'hC0 + b), 1'b0, 1'b0);
      chk("midwait_count", 32'(o_count), 32'd5);
      chk("midwait_busy", 32'(o_busy), 32'd1);
      apply_reset("rst_mid");
      starts_q.delete();
      for (int n = 0; n < 6; n++) cycle(1'b0, 8'h00, 1'b0, (n == 2));
      chk("post_rst_starts", 32'(starts_q.size()), 32'd0);
      chk("post_rst_count", 32'(o_count), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 1) == 1), 8'($urandom),
               ($urandom_range(0, 15) == 0),
               m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
